// File: rtl/tm1638_pkg.sv
// Shared constants and types for the TM1638-compatible serial slave.
package tm1638_pkg;

  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_DISP = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;

  localparam int RAM_DEPTH = 16;
  localparam int KEY_BYTES = 4;
  localparam int ADDR_W    = $clog2(RAM_DEPTH);
  localparam int RAM_W     = 8 * RAM_DEPTH;
  localparam int KEY_W     = 8 * KEY_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_IGNORE,
    ST_ERR
  } frame_state_t;

  function automatic logic [1:0] cmd_prefix(input logic [7:0] cmd);
    return cmd[7:6];
  endfunction

endpackage

// File: rtl/tm1638_sync.sv
// Multi-flop synchronizer with rise/fall detection; SYNC_STAGES must be >= 2.
module tm1638_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_VAL    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] meta_p0;
  logic                   prev_p1;
  logic [SYNC_STAGES:0]   primed_q;

  // Edges are suppressed until the chain holds real samples, so an input that
  // sat at the non-idle level through reset is not reported as a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0  <= {SYNC_STAGES{IDLE_VAL}};
      prev_p1  <= IDLE_VAL;
      primed_q <= '0;
    end else begin
      meta_p0  <= {meta_p0[SYNC_STAGES-2:0], async_i};
      prev_p1  <= meta_p0[SYNC_STAGES-1];
      primed_q <= {primed_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sync_o = meta_p0[SYNC_STAGES-1];
  assign rise   = primed_q[SYNC_STAGES] &  sync_o & ~prev_p1;
  assign fall   = primed_q[SYNC_STAGES] & ~sync_o &  prev_p1;

endmodule

// File: rtl/tm1638_slave.sv
// TM1638-style serial slave: command decode, 16-byte display RAM, key readout.
module tm1638_slave
  import tm1638_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk_i,
  input  logic             cs_n_i,
  input  logic             dio_i,
  output logic             dio_o,
  output logic             dio_oe,
  input  logic [KEY_W-1:0] key_data,
  output logic [RAM_W-1:0] disp_ram,
  output logic             disp_on,
  output logic [2:0]       brightness,
  output logic             frame_done,
  output logic             cmd_err
);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_n_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] dio_meta_p0;
  logic dio_s;

  tm1638_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_i(sclk_i),
    .sync_o(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  tm1638_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .async_i(cs_n_i),
    .sync_o(cs_n_s), .rise(cs_rise), .fall(cs_fall)
  );

  // DIO only needs the same latency as SCLK so samples line up with its edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dio_meta_p0 <= '0;
    else        dio_meta_p0 <= {dio_meta_p0[SYNC_STAGES-2:0], dio_i};
  end
  assign dio_s = dio_meta_p0[SYNC_STAGES-1];

  frame_state_t state_q, state_d;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shreg_q;
  logic [ADDR_W-1:0] addr_q;
  logic              fixed_q;
  logic [KEY_W-1:0]  key_sr_q;
  logic              rd_pend_q;
  logic              frame_done_d, cmd_err_d;
  logic              bit_rise, byte_done;
  logic [7:0]        byte_val;

  assign bit_rise  = sclk_rise & ~cs_n_s & ~dio_oe & (state_q != ST_IDLE);
  assign byte_done = bit_rise & (bit_cnt_q == 3'd7);
  assign byte_val  = {dio_s, shreg_q[7:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      frame_done <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_done <= frame_done_d;
      cmd_err    <= cmd_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    cmd_err_d    = 1'b0;
    if (cs_fall) begin
      state_d = ST_CMD;
    end else if (cs_rise) begin
      if (state_q != ST_IDLE && state_q != ST_ERR) begin
        if (bit_cnt_q != 3'd0)
          cmd_err_d = 1'b1;
        else if (state_q == ST_WRITE || state_q == ST_IGNORE)
          frame_done_d = 1'b1;
      end
      state_d = ST_IDLE;
    end else if (byte_done && state_q == ST_CMD) begin
      case (cmd_prefix(byte_val))
        CMD_DATA, CMD_DISP: state_d = ST_IGNORE;
        CMD_ADDR:           state_d = ST_WRITE;
        default: begin
          state_d   = ST_ERR;
          cmd_err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      addr_q     <= '0;
      fixed_q    <= 1'b0;
      key_sr_q   <= '0;
      rd_pend_q  <= 1'b0;
      dio_o      <= 1'b0;
      dio_oe     <= 1'b0;
      disp_ram   <= '0;
      disp_on    <= 1'b0;
      brightness <= '0;
    end else begin
      if (cs_fall) begin
        bit_cnt_q <= '0;
      end else if (bit_rise) begin
        shreg_q   <= byte_val;
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end

      if (byte_done) begin
        if (state_q == ST_CMD) begin
          case (cmd_prefix(byte_val))
            CMD_DATA: begin
              fixed_q <= byte_val[2];
              if (byte_val[1]) begin
                key_sr_q  <= key_data;
                rd_pend_q <= 1'b1;
              end
            end
            CMD_DISP: begin
              disp_on    <= byte_val[3];
              brightness <= byte_val[2:0];
            end
            CMD_ADDR: addr_q <= byte_val[ADDR_W-1:0];
            default: ;
          endcase
        end else if (state_q == ST_WRITE) begin
          disp_ram[{addr_q, 3'b000} +: 8] <= byte_val;
          if (!fixed_q) addr_q <= addr_q + 1'b1;
        end
      end

      // Readout shifts zeros in behind the key bits, so DIO idles low after bit 31.
      if (cs_rise) begin
        dio_oe    <= 1'b0;
        dio_o     <= 1'b0;
        rd_pend_q <= 1'b0;
      end else if (sclk_fall && !cs_n_s && (rd_pend_q || dio_oe)) begin
        dio_oe    <= 1'b1;
        rd_pend_q <= 1'b0;
        dio_o     <= key_sr_q[0];
        key_sr_q  <= {1'b0, key_sr_q[KEY_W-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_tm1638_slave.sv
// Directed bench for tm1638_slave: serial frames driven by a behavioural master.
module tb_tm1638_slave;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sclk_i, cs_n_i, dio_i;
  logic         dio_o, dio_oe;
  logic [31:0]  key_data;
  logic [127:0] disp_ram;
  logic         disp_on;
  logic [2:0]   brightness;
  logic         frame_done, cmd_err;

  int n_checks = 0;
  int n_err    = 0;
  int fd_cnt   = 0;
  int ce_cnt   = 0;

  localparam time HALF_SCLK = 80ns;

  tm1638_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .sclk_i(sclk_i), .cs_n_i(cs_n_i), .dio_i(dio_i),
    .dio_o(dio_o), .dio_oe(dio_oe),
    .key_data(key_data), .disp_ram(disp_ram),
    .disp_on(disp_on), .brightness(brightness),
    .frame_done(frame_done), .cmd_err(cmd_err)
  );

  always #5ns clk = ~clk;

  always @(posedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (cmd_err)    ce_cnt <= ce_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cs_low();
    cs_n_i = 1'b0;
    #(HALF_SCLK);
  endtask

  task automatic cs_high();
    sclk_i = 1'b1;
    #(HALF_SCLK);
    cs_n_i = 1'b1;
    #(HALF_SCLK);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sclk_i = 1'b0;
      dio_i  = b[i];
      #(HALF_SCLK);
      sclk_i = 1'b1;
      #(HALF_SCLK);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic read_byte(output logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      sclk_i = 1'b0;
      dio_i  = 1'b1;
      #(HALF_SCLK);
      b[i]   = dio_o;
      sclk_i = 1'b1;
      #(HALF_SCLK);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rb;
    int fd0, ce0;

    rst_n    = 1'b0;
    sclk_i   = 1'b1;
    cs_n_i   = 1'b1;
    dio_i    = 1'b0;
    key_data = 32'h8040_2001;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_disp_ram",   disp_ram,   '0);
    check("rst_disp_on",    disp_on,    '0);
    check("rst_brightness", brightness, '0);
    check("rst_dio_oe",     dio_oe,     '0);
    check("rst_dio_o",      dio_o,      '0);
    check("rst_pulses",     {frame_done, cmd_err}, '0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // Write mode, auto increment from address 0.
    cs_low(); send_byte(8'h40); cs_high();
    cs_low(); send_byte(8'hC0); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); cs_high();
    #100ns;
    check("auto_write_ram", disp_ram, 128'h33_2211);
    check("auto_write_fd",  fd_cnt,   2);
    check("auto_write_ce",  ce_cnt,   0);

    // Fixed address: both bytes land in address 5.
    cs_low(); send_byte(8'h44); cs_high();
    cs_low(); send_byte(8'hC5); send_byte(8'hAA); send_byte(8'hBB); cs_high();
    #100ns;
    check("fixed_write_ram", disp_ram, 128'hBB00_0033_2211);

    // Auto mode again, start at 15 and wrap to 0.
    cs_low(); send_byte(8'h40); cs_high();
    cs_low(); send_byte(8'hCF); send_byte(8'h01); send_byte(8'h02); cs_high();
    #100ns;
    check("wrap_byte15", disp_ram[127:120], 8'h01);
    check("wrap_byte0",  disp_ram[7:0],     8'h02);
    check("wrap_mid",    disp_ram[119:8],   112'hBB00_0033_22);

    // Key readout.
    fd0 = fd_cnt;
    cs_low(); send_byte(8'h42);
    read_byte(rb); check("key_byte0", rb, 8'h01);
    read_byte(rb); check("key_byte1", rb, 8'h20);
    read_byte(rb); check("key_byte2", rb, 8'h40);
    read_byte(rb); check("key_byte3", rb, 8'h80);
    check("read_oe_held", dio_oe, 1'b1);
    cs_high();
    #60ns;
    check("read_oe_drop", dio_oe, 1'b0);
    check("read_fd", fd_cnt - fd0, 1);
    check("read_ram_kept", disp_ram[7:0], 8'h02);

    // Display control, then an illegal command.
    cs_low(); send_byte(8'h8C); cs_high();
    #100ns;
    check("disp_on",    disp_on,    1'b1);
    check("brightness", brightness, 3'd4);
    fd0 = fd_cnt; ce0 = ce_cnt;
    cs_low(); send_byte(8'h05); send_byte(8'hFF); cs_high();
    #100ns;
    check("bad_cmd_ce",      ce_cnt - ce0, 1);
    check("bad_cmd_no_fd",   fd_cnt - fd0, 0);
    check("bad_cmd_disp",    {disp_on, brightness}, {1'b1, 3'd4});
    check("bad_cmd_ram",     disp_ram[15:0], 16'h2202);

    // Partial byte at frame end.
    fd0 = fd_cnt; ce0 = ce_cnt;
    cs_low(); send_bits(8'hC0, 5); cs_high();
    #100ns;
    check("partial_ce",    ce_cnt - ce0, 1);
    check("partial_no_fd", fd_cnt - fd0, 0);

    // Reset in the middle of a write frame.
    cs_low(); send_byte(8'hC3); send_bits(8'h55, 3);
    rst_n = 1'b0;
    #20ns;
    check("midrst_ram",    disp_ram,   '0);
    check("midrst_disp",   {disp_on, brightness}, '0);
    check("midrst_dio",    {dio_oe, dio_o}, '0);
    check("midrst_pulses", {frame_done, cmd_err}, '0);
    cs_n_i = 1'b1;
    sclk_i = 1'b1;
    #50ns;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    cs_low(); send_byte(8'h8A); cs_high();
    #100ns;
    check("post_rst_disp", {disp_on, brightness}, {1'b1, 3'd2});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/tm1638_slave.md
TM1638_SLAVE -- requirements
Module: tm1638_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2, input synchronizer depth for SCLK/CS_n/DIO.
REQ-002 clk  input  1  system clock, rising-edge; frequency SHALL be >= 8x SCLK.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 sclk_i  input  1  serial clock from TM1638 master, asynchronous to clk.
REQ-005 cs_n_i  input  1  active-low frame strobe from master.
REQ-006 dio_i  input  1  serial data from master.
REQ-007 dio_o  output  1  serial read data to master.
REQ-008 dio_oe  output  1  high while slave drives DIO.
REQ-009 key_data  input  32  key scan bytes; byte0 = bits[7:0], sent first.
REQ-010 disp_ram  output  128  16 display bytes; address n at bits[8n+7:8n].
REQ-011 disp_on  output  1  display enable from display-control command.
REQ-012 brightness  output  3  brightness from display-control command.
REQ-013 frame_done  output  1  one-clk pulse at end of a valid frame.
REQ-014 cmd_err  output  1  one-clk pulse on protocol error.

Function
REQ-015 sclk_i, cs_n_i, dio_i SHALL pass SYNC_STAGES flops; edges detected on synchronized SCLK/CS_n only.
REQ-016 Frame = CS_n low interval; CS_n falling edge SHALL clear bit counter and mark next byte as command byte.
REQ-017 Bits SHALL be sampled from synchronized DIO on SCLK rising edge, LSB first; byte complete at 8th rising edge.
REQ-018 Command byte decode on bits[7:6]: 01 data command, 10 display control, 11 address set, 00 -> cmd_err, rest of frame ignored.
REQ-019 Data command: bit1 = read mode, bit2 = fixed address; mode SHALL persist across frames until next data command.
REQ-020 Address set: addr <= bits[3:0]; each following byte in same frame SHALL write disp_ram[addr]; auto mode addr increments mod 16 (15 wraps to 0); fixed mode addr unchanged.
REQ-021 Display control: disp_on <= bit3, brightness <= bits[2:0], on byte completion.
REQ-022 Read: after data command with bit1=1 completes, slave SHALL snapshot key_data into 32-bit shift register.
REQ-023 Read: on next SCLK falling edge dio_oe <= 1, dio_o <= bit0; each subsequent falling edge shifts to next bit; after bit31 dio_o <= 0, dio_oe held.
REQ-024 Read: incoming DIO bits SHALL be ignored while dio_oe = 1; dio_oe SHALL drop on the clk cycle after synchronized CS_n rises.
REQ-025 CS_n rising with bit counter != 0 SHALL pulse cmd_err and discard the partial byte.
REQ-026 CS_n rising after >= 1 complete byte and no error SHALL pulse frame_done one cycle.
REQ-027 Data bytes in a frame whose command was a data command or display control (not address set) SHALL be ignored without error.
REQ-028 SCLK edges while CS_n high SHALL have no effect.
REQ-029 disp_ram, disp_on, brightness update SHALL be visible the clk cycle after the completing SCLK edge is detected.

Reset
REQ-030 rst_n low SHALL asynchronously clear: disp_ram 0, disp_on 0, brightness 0, addr 0, mode write/auto, dio_o 0, dio_oe 0, frame_done 0, cmd_err 0, synchronizers to idle (SCLK 1, CS_n 1).
REQ-031 Reset mid-frame SHALL abandon the frame; first frame after release requires a fresh CS_n falling edge.

Structure
REQ-032 Package tm1638_pkg SHALL hold command prefix constants (data 2'b01, display 2'b10, address 2'b11), RAM depth 16, key byte count 4.
REQ-033 One sub-module tm1638_sync: SYNC_STAGES synchronizer plus rise/fall edge detect, instanced for SCLK and CS_n; DIO uses synchronizer only.

Verification
REQ-034 Frame 0x40; frame 0xC0,0x11,0x22,0x33 -> disp_ram bytes 0..2 = 11,22,33, two frame_done pulses.
REQ-035 Frame 0x44; frame 0xC5,0xAA,0xBB -> byte5 = BB, byte6 unchanged 00.
REQ-036 Auto mode frame 0xCF,0x01,0x02 -> byte15 = 01, byte0 = 02 (wrap).
REQ-037 key_data 0x8040_2001, frame 0x42 + 32 SCLKs -> master samples 0x01,0x20,0x40,0x80 LSB-first; dio_oe low after CS_n rise.
REQ-038 Frame 0x8C -> disp_on 1, brightness 4; frame 0x05 -> cmd_err pulse, state unchanged.
REQ-039 CS_n raised after 5 bits of 0xC0 -> cmd_err, no frame_done; rst_n low mid-write -> all outputs reset values.
